// File: rtl/jpeg_pkg.sv
// Shared definitions for the JPEG entropy-coded byte packer: codeword widths,
// marker/stuff byte values, the packer FSM encoding and the bit-mask helper.
package jpeg_pkg;

   localparam int CODE_W = 27;
   localparam int LEN_W  = 5;

   localparam logic [7:0] MARKER_FF  = 8'hFF;
   localparam logic [7:0] STUFF_BYTE = 8'h00;

   typedef enum logic [1:0] {
      ACCEPT = 2'd0,
      EMIT   = 2'd1,
      STUFF  = 2'd2,
      PAD    = 2'd3
   } state_t;

   // Low 'len' bits set; callers cast down to the width they need.
   function automatic logic [63:0] mask(input int unsigned len);
      mask = (64'd1 << len) - 64'd1;
   endfunction

endpackage

// File: rtl/jpeg_bit_packer.sv
// Packs right-aligned variable-length codewords MSB-first into scan bytes,
// stuffing 0x00 after every 0xFF and padding the last partial byte with 1s on flush.
module jpeg_bit_packer
   import jpeg_pkg::*;
#(
   parameter int CODE_W = jpeg_pkg::CODE_W,
   parameter int LEN_W  = jpeg_pkg::LEN_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CODE_W-1:0] in_code,
   input  logic [LEN_W-1:0]  in_len,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [7:0]        out_byte,
   output logic              flush_done,
   output logic              busy
);

   localparam int ACC_W = CODE_W + 7;
   localparam int CNT_W = $clog2(ACC_W + 1);
   localparam logic [CNT_W-1:0] BYTE_BITS = CNT_W'(8);
   localparam logic [LEN_W-1:0] MAX_LEN   = LEN_W'(CODE_W);

   state_t             state_q, state_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               flush_pend_q, flush_pend_d;
   logic               out_valid_d;
   logic [7:0]         out_byte_d;
   logic               flush_done_d;

   logic               accept;
   logic               handshake;
   logic               pend_eff;
   logic [LEN_W-1:0]   len_eff;
   logic [ACC_W-1:0]   acc_acc, acc_in;
   logic [CNT_W-1:0]   cnt_in, cnt_sub;
   logic [3:0]         fill;
   logic [7:0]         byte_in, byte_cur, byte_sub, pad_in;

   assign in_ready  = reset && (state_q == ACCEPT) && (cnt_q < BYTE_BITS) && !flush_pend_q;
   assign busy      = (cnt_q != '0) || flush_pend_q || (state_q != ACCEPT);
   assign accept    = in_valid && in_ready;
   assign handshake = out_valid && out_ready;
   assign pend_eff  = flush_pend_q || flush;

   // Lengths beyond the codeword width are clamped; code bits above the length are dropped.
   assign len_eff = (in_len > MAX_LEN) ? MAX_LEN : in_len;
   assign acc_acc = (acc_q << len_eff)
                  | ACC_W'(in_code & CODE_W'(mask(32'(len_eff))));
   assign acc_in  = accept ? acc_acc : acc_q;
   assign cnt_in  = accept ? (cnt_q + CNT_W'(len_eff)) : cnt_q;
   assign cnt_sub = cnt_q - BYTE_BITS;

   // Byte-extract mux: the oldest 8 valid bits sit at acc[cnt-1 -: 8].
   assign byte_in  = 8'(acc_in >> (cnt_in  - BYTE_BITS));
   assign byte_cur = 8'(acc_q  >> (cnt_q   - BYTE_BITS));
   assign byte_sub = 8'(acc_q  >> (cnt_sub - BYTE_BITS));

   // Residue bits shift into the top of the byte; stale bits above them fall off.
   assign fill   = 4'(BYTE_BITS - cnt_in);
   assign pad_in = (acc_in[7:0] << fill) | 8'(mask(32'(fill)));

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk) begin
      if (!reset) state_q <= ACCEPT;
      else        state_q <= state_d;
   end

   // NOTE: every variable gets a default before the case so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ACCEPT: begin
            if (cnt_in >= BYTE_BITS)           state_d = EMIT;
            else if (pend_eff && cnt_in != '0) state_d = PAD;
         end
         EMIT: begin
            if (handshake) begin
               if (out_byte == MARKER_FF)     state_d = STUFF;
               else if (cnt_sub >= BYTE_BITS) state_d = EMIT;
               else                           state_d = ACCEPT;
            end
         end
         STUFF: begin
            if (handshake) state_d = (cnt_q >= BYTE_BITS) ? EMIT : ACCEPT;
         end
         PAD: begin
            if (handshake) state_d = (out_byte == MARKER_FF) ? STUFF : ACCEPT;
         end
         default: state_d = ACCEPT;
      endcase
   end

   always_comb begin
      acc_d        = acc_q;
      cnt_d        = cnt_q;
      flush_pend_d = pend_eff;
      out_valid_d  = out_valid;
      out_byte_d   = out_byte;
      flush_done_d = 1'b0;
      case (state_q)
         ACCEPT: begin
            acc_d = acc_in;
            cnt_d = cnt_in;
            if (cnt_in >= BYTE_BITS) begin
               out_valid_d = 1'b1;
               out_byte_d  = byte_in;
            end else if (pend_eff) begin
               if (cnt_in == '0) begin
                  flush_done_d = 1'b1;
                  flush_pend_d = 1'b0;
               end else begin
                  out_valid_d = 1'b1;
                  out_byte_d  = pad_in;
               end
            end
         end
         EMIT: begin
            if (handshake) begin
               cnt_d = cnt_sub;
               if (out_byte == MARKER_FF) begin
                  out_byte_d = STUFF_BYTE;
               end else if (cnt_sub >= BYTE_BITS) begin
                  out_byte_d = byte_sub;
               end else begin
                  out_valid_d = 1'b0;
                  if (pend_eff && cnt_sub == '0) begin
                     flush_done_d = 1'b1;
                     flush_pend_d = 1'b0;
                  end
               end
            end
         end
         STUFF: begin
            if (handshake) begin
               if (cnt_q >= BYTE_BITS) begin
                  out_byte_d = byte_cur;
               end else begin
                  out_valid_d = 1'b0;
                  // A stuff byte following the pad byte completes the flush.
                  if (pend_eff && cnt_q == '0) begin
                     flush_done_d = 1'b1;
                     flush_pend_d = 1'b0;
                  end
               end
            end
         end
         PAD: begin
            if (handshake) begin
               cnt_d = '0;
               if (out_byte == MARKER_FF) begin
                  out_byte_d = STUFF_BYTE;
               end else begin
                  out_valid_d  = 1'b0;
                  flush_done_d = 1'b1;
                  flush_pend_d = 1'b0;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         acc_q        <= '0;
         cnt_q        <= '0;
         flush_pend_q <= 1'b0;
         out_valid    <= 1'b0;
         out_byte     <= 8'h00;
         flush_done   <= 1'b0;
      end else begin
         acc_q        <= acc_d;
         cnt_q        <= cnt_d;
         flush_pend_q <= flush_pend_d;
         out_valid    <= out_valid_d;
         out_byte     <= out_byte_d;
         flush_done   <= flush_done_d;
      end
   end

endmodule
